baud_ctrl: RTL and testbench

Runtime-configurable baud tick controller for the UART path. Owns the baud divide counter, accepts new divisors over a valid/ready handshake, and applies them only on a tick boundary so no shortened or stretched baud period is emitted. Drives the oversample tick and the per-bit tick consumed by the UART TX/RX and morse timing logic.

---
 rtl/baud_ctrl.sv | 148 ++++++++++++++
 tb/tb_baud_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_ctrl.sv
// Baud tick controller: divides clk_i by a runtime divisor into oversample and bit ticks,
// swapping in new divisors only at a tick boundary so no baud period is ever cut or stretched.
module baud_ctrl #(
    parameter int N           = 10,
    parameter int DEFAULT_DIV = 651,
    parameter int OVERSAMPLE  = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         enable_i,
    input  logic [N-1:0] div_i,
    input  logic         div_valid_i,
    output logic         div_ready_o,
    output logic         tick_o,
    output logic         bit_tick_o,
    output logic [N-1:0] count_o,
    output logic [N-1:0] div_o,
    output logic         pending_o
);

    localparam int SW = $clog2(OVERSAMPLE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  count_r, count_s;
    logic [N-1:0]  div_r, div_s;
    logic [N-1:0]  shadow_r, shadow_s;
    logic [SW-1:0] sub_r, sub_s;
    logic [SW-1:0] sub_inc_s;
    logic          ready_s;
    logic          xfer_s;
    logic          tick_s;

    // A divisor below 2 cannot produce a one-cycle tick followed by a gap.
    function automatic logic [N-1:0] clamp_div(input logic [N-1:0] d);
        if (d < N'(2)) begin
            return N'(2);
        end else begin
            return d;
        end
    endfunction

    assign ready_s   = (state_r != PENDING);
    assign xfer_s    = div_valid_i && ready_s;
    assign tick_s    = (state_r != IDLE) && (count_r == (div_r - N'(1)));
    assign sub_inc_s = (sub_r == SW'(OVERSAMPLE - 1)) ? {SW{1'b0}} : (sub_r + SW'(1));

    // Next-state and datapath decode for the three-state controller.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        div_s    = div_r;
        shadow_s = shadow_r;
        sub_s    = sub_r;
        case (state_r)
            IDLE: begin
                count_s = {N{1'b0}};
                sub_s   = {SW{1'b0}};
                if (xfer_s) begin
                    div_s = clamp_div(div_i);
                end else begin
                    div_s = div_r;
                end
                if (enable_i) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_s = IDLE;
                    count_s = {N{1'b0}};
                    sub_s   = {SW{1'b0}};
                    if (xfer_s) begin
                        div_s = clamp_div(div_i);
                    end else begin
                        div_s = div_r;
                    end
                end else begin
                    if (tick_s) begin
                        count_s = {N{1'b0}};
                        sub_s   = sub_inc_s;
                    end else begin
                        count_s = count_r + N'(1);
                    end
                    // A transfer on a tick edge lands in the shadow, so it waits a full period.
                    if (xfer_s) begin
                        shadow_s = clamp_div(div_i);
                        state_s  = PENDING;
                    end else begin
                        state_s  = RUN;
                    end
                end
            end
            PENDING: begin
                if (!enable_i) begin
                    state_s = IDLE;
                    count_s = {N{1'b0}};
                    sub_s   = {SW{1'b0}};
                    div_s   = shadow_r;
                end else if (tick_s) begin
                    state_s = RUN;
                    count_s = {N{1'b0}};
                    sub_s   = sub_inc_s;
                    div_s   = shadow_r;
                end else begin
                    count_s = count_r + N'(1);
                end
            end
            default: begin
                state_s = IDLE;
                count_s = {N{1'b0}};
                sub_s   = {SW{1'b0}};
            end
        endcase
    end

    // State, counters and divisor registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            count_r  <= {N{1'b0}};
            div_r    <= N'(DEFAULT_DIV);
            shadow_r <= N'(DEFAULT_DIV);
            sub_r    <= {SW{1'b0}};
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            div_r    <= div_s;
            shadow_r <= shadow_s;
            sub_r    <= sub_s;
        end
    end

    assign div_ready_o = ready_s;
    assign pending_o   = (state_r == PENDING);
    assign tick_o      = tick_s;
    assign bit_tick_o  = tick_s && (sub_r == SW'(OVERSAMPLE - 1));
    assign count_o     = count_r;
    assign div_o       = div_r;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a period/queue based reference model.
module tb_baud_ctrl;

    localparam int N   = 10;
    localparam int DEF = 651;
    localparam int OS  = 16;

    logic         clk_i;
    logic         reset_i;
    logic         enable_i;
    logic [N-1:0] div_i;
    logic         div_valid_i;
    logic         div_ready_o;
    logic         tick_o;
    logic         bit_tick_o;
    logic [N-1:0] count_o;
    logic [N-1:0] div_o;
    logic         pending_o;

    baud_ctrl #(.N(N), .DEFAULT_DIV(DEF), .OVERSAMPLE(OS)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .tick_o      (tick_o),
        .bit_tick_o  (bit_tick_o),
        .count_o     (count_o),
        .div_o       (div_o),
        .pending_o   (pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed cycles in the current period, ticks since start, queued divisor.
    bit m_run;
    int m_phase;
    int m_div;
    int m_ticks;
    int m_q[$];

    int obs_tick, obs_bit, obs_count, obs_pend, obs_ready, obs_div;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_phase = 0;
        m_div   = DEF;
        m_ticks = 0;
        m_q.delete();
    endtask

    // One clock: compare at negedge, advance the model, return 1 time unit after the posedge.
    task automatic cyc();
        bit exp_tick, exp_bit, pend, xfer;
        int v;
        @(negedge clk_i);
        pend     = (m_q.size() != 0);
        exp_tick = m_run && (m_phase == m_div - 1);
        exp_bit  = exp_tick && ((m_ticks % OS) == OS - 1);
        check_eq("count", count_o, m_phase);
        check_eq("div", div_o, m_div);
        check_eq("tick", tick_o, exp_tick);
        check_eq("bit_tick", bit_tick_o, exp_bit);
        check_eq("pending", pending_o, pend);
        check_eq("ready", div_ready_o, !pend);
        obs_tick  = tick_o;
        obs_bit   = bit_tick_o;
        obs_count = count_o;
        obs_pend  = pending_o;
        obs_ready = div_ready_o;
        obs_div   = div_o;
        xfer = div_valid_i && !pend;
        v    = (int'(div_i) < 2) ? 2 : int'(div_i);
        if (!m_run) begin
            m_phase = 0;
            m_ticks = 0;
            if (xfer) m_div = v;
            if (enable_i) m_run = 1'b1;
        end else if (!enable_i) begin
            m_run   = 1'b0;
            m_phase = 0;
            m_ticks = 0;
            if (pend) m_div = m_q.pop_front();
            else if (xfer) m_div = v;
        end else begin
            if (exp_tick) begin
                m_phase = 0;
                m_ticks++;
                if (pend) m_div = m_q.pop_front();
            end else begin
                m_phase++;
            end
            if (xfer) m_q.push_back(v);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Asynchronous reset pulse placed between edges; outputs must react immediately.
    task automatic do_reset();
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("rst_count", count_o, 0);
        check_eq("rst_div", div_o, DEF);
        check_eq("rst_tick", tick_o, 0);
        check_eq("rst_bit_tick", bit_tick_o, 0);
        check_eq("rst_ready", div_ready_o, 1);
        check_eq("rst_pending", pending_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!obs_tick && n < bound);
        check_eq("tick_seen", obs_tick, 1);
    endtask

    task automatic run_to_count(input int target);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (obs_count != target && k < 2000);
        check_eq("reach_count", obs_count, target);
    endtask

    initial begin
        int n, k, t;
        reset_i     = 1'b0;
        enable_i    = 1'b0;
        div_valid_i = 1'b0;
        div_i       = '0;
        model_reset();
        #1;
        do_reset();

        // First tick at default divisor, then wrap.
        enable_i = 1'b1;
        cyc();
        wait_tick(2000, n);
        check_eq("first_tick_cycles", n, DEF);
        check_eq("first_tick_count", obs_count, DEF - 1);
        repeat (3) cyc();
        check_eq("count_after3", obs_count, 2);
        check_eq("tick_after3", obs_tick, 0);

        // bit_tick only on the 16th tick, then every div*OS cycles.
        k = 1;
        while (!obs_bit && k < 20) begin
            wait_tick(1000, n);
            k++;
        end
        check_eq("bit_tick_index", k, OS);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!obs_bit && n < 20000);
        check_eq("bit_tick_spacing", n, DEF * OS);

        // Mid-period update at count 300 applies at the next tick.
        enable_i = 1'b0;
        do_reset();
        enable_i = 1'b1;
        cyc();
        run_to_count(299);
        div_valid_i = 1'b1;
        div_i       = 10'd100;
        cyc();
        div_valid_i = 1'b0;
        cyc();
        check_eq("pend_set", obs_pend, 1);
        check_eq("ready_low", obs_ready, 0);
        wait_tick(1000, n);
        check_eq("old_tick_count", obs_count, DEF - 1);
        wait_tick(1000, n);
        check_eq("new_period", n, 100);
        check_eq("pend_clear", obs_pend, 0);

        // Divisor 0 in IDLE clamps to 2: tick every other cycle.
        enable_i = 1'b0;
        do_reset();
        div_valid_i = 1'b1;
        div_i       = 10'd0;
        cyc();
        div_valid_i = 1'b0;
        cyc();
        check_eq("clamp_div", obs_div, 2);
        enable_i = 1'b1;
        cyc();
        t = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            t += obs_tick;
        end
        check_eq("div2_ticks", t, 5);

        // Transfer coincident with a tick waits one more old-length period.
        enable_i = 1'b0;
        do_reset();
        enable_i = 1'b1;
        cyc();
        run_to_count(DEF - 2);
        div_valid_i = 1'b1;
        div_i       = 10'd50;
        cyc();
        div_valid_i = 1'b0;
        check_eq("xfer_on_tick", obs_tick, 1);
        wait_tick(1000, n);
        check_eq("old_len_period", n, DEF);
        wait_tick(1000, n);
        check_eq("after_tick_xfer", n, 50);

        // Async reset mid-PENDING discards the shadow.
        enable_i = 1'b0;
        do_reset();
        enable_i = 1'b1;
        cyc();
        run_to_count(9);
        div_valid_i = 1'b1;
        div_i       = 10'd7;
        cyc();
        div_valid_i = 1'b0;
        cyc();
        check_eq("pend_before_rst", obs_pend, 1);
        enable_i = 1'b0;
        do_reset();
        t = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            t += obs_tick;
        end
        check_eq("no_tick_after_rst", t, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            enable_i    = ($urandom_range(0, 399) != 0);
            div_valid_i = ($urandom_range(0, 19) == 0);
            div_i       = N'($urandom_range(0, 12));
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
            end else begin
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
